// File: rtl/overlay_pkg.sv
// Shared types and defaults for the overlay marker-position path.
package overlay_pkg;

  localparam int XW        = 11;
  localparam int YW        = 10;
  localparam int X_MAX_DEF = 1280;
  localparam int Y_MAX_DEF = 720;

  typedef enum logic {
    HIDDEN = 1'b0,
    SHOWN  = 1'b1
  } ovl_state_e;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          src;
  } coord_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer only moves when both sides request.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic ptr_q;

  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = ptr_q ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst)                  ptr_q <= 1'b0;
    else if (valid == 2'b11)  ptr_q <= ~ptr_q;
  end

endmodule

// File: rtl/overlay_pos_ctrl.sv
// Arbitrates A/B marker coordinates and commits them at vsync rising edges.
// Optional overwrite statistics are built when OVERLAY_POS_STATS_EN is defined.
module overlay_pos_ctrl
  import overlay_pkg::*;
#(
  parameter int X_MAX          = X_MAX_DEF,
  parameter int Y_MAX          = Y_MAX_DEF,
  parameter int TIMEOUT_FRAMES = 30
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vsync_in,
  input  logic          a_valid,
  input  logic [XW-1:0] a_x,
  input  logic [YW-1:0] a_y,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [XW-1:0] b_x,
  input  logic [YW-1:0] b_y,
  output logic          b_ready,
  output logic [31:0]   x_out,
  output logic [31:0]   y_out,
  output logic          marker_en,
  output logic          src_b,
  output logic [15:0]   drop_cnt
);

  localparam logic [XW-1:0] X_LIM = XW'(X_MAX - 1);
  localparam logic [YW-1:0] Y_LIM = YW'(Y_MAX - 1);

  // Handshake: ready is combinational from valid and the arbiter pointer;
  // a transfer happens on any clock where valid && ready, and the requester
  // must hold its data stable while valid is high and ready is low.
  logic [1:0] grant;
  logic       accept;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid ({b_valid, a_valid}),
    .grant (grant)
  );

  assign a_ready = grant[0];
  assign b_ready = grant[1];
  assign accept  = |grant;

  coord_t        acc_c;
  logic [XW-1:0] sel_x;
  logic [YW-1:0] sel_y;

  always_comb begin
    sel_x     = grant[1] ? b_x : a_x;
    sel_y     = grant[1] ? b_y : a_y;
    acc_c     = '0;
    acc_c.x   = (sel_x > X_LIM) ? X_LIM : sel_x;
    acc_c.y   = (sel_y > Y_LIM) ? Y_LIM : sel_y;
    acc_c.src = grant[1];
  end

  ovl_state_e    state_q, state_d;
  logic [7:0]    miss_q, miss_d;
  logic [8:0]    miss_inc;
  coord_t        pend_q;
  logic          pend_v_q;
  logic          vs_d;
  logic          vs_rise;
  logic          commit;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          src_q;

  assign vs_rise  = vsync_in & ~vs_d;
  assign miss_inc = {1'b0, miss_q} + 9'd1;

  always_comb begin
    state_d = state_q;
    miss_d  = miss_q;
    commit  = 1'b0;
    if (vs_rise) begin
      case (state_q)
        HIDDEN: begin
          if (pend_v_q) begin
            commit  = 1'b1;
            state_d = SHOWN;
            miss_d  = '0;
          end
        end
        SHOWN: begin
          if (pend_v_q) begin
            commit = 1'b1;
            miss_d = '0;
          end else if (miss_inc == 9'(TIMEOUT_FRAMES)) begin
            state_d = HIDDEN;
            miss_d  = '0;
          end else begin
            miss_d = miss_inc[7:0];
          end
        end
        default: state_d = HIDDEN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HIDDEN;
      miss_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      vs_d     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      src_q    <= 1'b0;
    end else begin
      vs_d    <= vsync_in;
      state_q <= state_d;
      miss_q  <= miss_d;
      if (commit) begin
        x_q   <= pend_q.x;
        y_q   <= pend_q.y;
        src_q <= pend_q.src;
      end
      // A same-cycle accept wins over the clear: the commit used the old data.
      if (accept) begin
        pend_q   <= acc_c;
        pend_v_q <= 1'b1;
      end else if (commit) begin
        pend_v_q <= 1'b0;
      end
    end
  end

  assign x_out     = {{(32-XW){1'b0}}, x_q};
  assign y_out     = {{(32-YW){1'b0}}, y_q};
  assign marker_en = (state_q == SHOWN);
  assign src_b     = src_q;

`ifdef OVERLAY_POS_STATS_EN
  logic [15:0] drop_q;

  always_ff @(posedge clk) begin
    if (rst)
      drop_q <= '0;
    else if (accept && pend_v_q && !commit && (drop_q != 16'hFFFF))
      drop_q <= drop_q + 16'd1;
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_overlay_pos_ctrl.sv
// Directed bench for overlay_pos_ctrl with hand-computed expected commits.
module tb_overlay_pos_ctrl;

  localparam int W = 22;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync_in = 1'b0;
  logic        a_valid = 1'b0;
  logic [10:0] a_x = '0;
  logic [9:0]  a_y = '0;
  logic        a_ready;
  logic        b_valid = 1'b0;
  logic [10:0] b_x = '0;
  logic [9:0]  b_y = '0;
  logic        b_ready;
  logic [31:0] x_out, y_out;
  logic        marker_en, src_b;
  logic [15:0] drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  overlay_pos_ctrl #(
    .X_MAX          (1280),
    .Y_MAX          (720),
    .TIMEOUT_FRAMES (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .vsync_in  (vsync_in),
    .a_valid   (a_valid),
    .a_x       (a_x),
    .a_y       (a_y),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_x       (b_x),
    .b_y       (b_y),
    .b_ready   (b_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .marker_en (marker_en),
    .src_b     (src_b),
    .drop_cnt  (drop_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // drivers
  task automatic send(input bit use_b, input logic [10:0] x, input logic [9:0] y);
    bit done;
    done = 1'b0;
    if (use_b) begin b_valid = 1'b1; b_x = x; b_y = y; end
    else       begin a_valid = 1'b1; a_x = x; a_y = y; end
    #1;
    for (int i = 0; i < 16 && !done; i++) begin
      if (use_b ? b_ready : a_ready) done = 1'b1;
      tick();
    end
    chk("accept_seen", 32'(done), 32'd1);
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic vsync_pulse(input int hold);
    vsync_in = 1'b1;
    tick();
    repeat (hold - 1) tick();
    vsync_in = 1'b0;
    tick();
  endtask

  // scoreboard
  task automatic push_frame(input logic [10:0] x, input logic [9:0] y, input logic src);
    exp_q.push_back({src, y, x});
  endtask

  task automatic check_frame(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_exp_q_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_x"},   x_out, 32'(e[10:0]));
      chk({tag, "_y"},   y_out, 32'(e[20:11]));
      chk({tag, "_src"}, 32'(src_b), 32'(e[21]));
      chk({tag, "_en"},  32'(marker_en), 32'd1);
    end
  endtask

  initial begin
    do_reset();
    chk("rst_x", x_out, 32'd0);
    chk("rst_y", y_out, 32'd0);
    chk("rst_en", 32'(marker_en), 32'd0);
    chk("rst_src", 32'(src_b), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_ready", 32'({a_ready, b_ready}), 32'd0);

    // idle frames keep the marker hidden
    for (int i = 0; i < 3; i++) begin
      vsync_pulse(2);
      chk("idle_en", 32'(marker_en), 32'd0);
      chk("idle_x", x_out, 32'd0);
    end

    // single A update, checked one cycle after vsync first samples high
    send(1'b0, 11'd640, 10'd360);
    push_frame(11'd640, 10'd360, 1'b0);
    vsync_in = 1'b1;
    tick();
    check_frame("a_commit");
    tick();
    vsync_in = 1'b0;
    tick();

    // contested requests: A first, then B
    a_valid = 1'b1; a_x = 11'd10; a_y = 10'd20;
    b_valid = 1'b1; b_x = 11'd30; b_y = 10'd40;
    #1;
    chk("rr1_a_ready", 32'(a_ready), 32'd1);
    chk("rr1_b_ready", 32'(b_ready), 32'd0);
    tick();
    a_x = 11'd11; a_y = 10'd21;
    chk("rr2_a_ready", 32'(a_ready), 32'd0);
    chk("rr2_b_ready", 32'(b_ready), 32'd1);
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    push_frame(11'd30, 10'd40, 1'b1);
    vsync_pulse(2);
    check_frame("rr_commit");

    // clamping, including the exact limit and one past it
    send(1'b1, 11'd2000, 10'd900);
    push_frame(11'd1279, 10'd719, 1'b1);
    vsync_pulse(2);
    check_frame("clamp_b");
    send(1'b0, 11'd1280, 10'd720);
    push_frame(11'd1279, 10'd719, 1'b0);
    vsync_pulse(2);
    check_frame("clamp_edge");
    send(1'b0, 11'd1279, 10'd0);
    push_frame(11'd1279, 10'd0, 1'b0);
    vsync_pulse(2);
    check_frame("clamp_in_range");

    // timeout after 3 empty frames; a long vsync is still one frame
    vsync_pulse(5);
    chk("to1_en", 32'(marker_en), 32'd1);
    vsync_pulse(2);
    chk("to2_en", 32'(marker_en), 32'd1);
    vsync_pulse(2);
    chk("to3_en", 32'(marker_en), 32'd0);
    chk("to3_x_hold", x_out, 32'd1279);
    send(1'b0, 11'd5, 10'd6);
    push_frame(11'd5, 10'd6, 1'b0);
    vsync_pulse(2);
    check_frame("reshow");

    // accept on the vs_rise cycle: old pending commits, new one waits
    send(1'b0, 11'd100, 10'd50);
    a_valid = 1'b1; a_x = 11'd200; a_y = 10'd60;
    vsync_in = 1'b1;
    push_frame(11'd100, 10'd50, 1'b0);
    tick();
    a_valid = 1'b0;
    check_frame("overlap_old");
    tick();
    vsync_in = 1'b0;
    tick();
    push_frame(11'd200, 10'd60, 1'b0);
    vsync_pulse(2);
    check_frame("overlap_new");

    // accept on vs_rise with nothing pending: no commit this frame
    a_valid = 1'b1; a_x = 11'd9; a_y = 10'd9;
    vsync_in = 1'b1;
    tick();
    a_valid = 1'b0;
    chk("empty_overlap_x", x_out, 32'd200);
    chk("empty_overlap_en", 32'(marker_en), 32'd1);
    vsync_in = 1'b0;
    tick();
    push_frame(11'd9, 10'd9, 1'b0);
    vsync_pulse(2);
    check_frame("empty_overlap_next");

    // reset with a pending update discards it
    send(1'b0, 11'd7, 10'd7);
    do_reset();
    chk("midrst_en", 32'(marker_en), 32'd0);
    chk("midrst_x", x_out, 32'd0);
    vsync_pulse(2);
    chk("midrst_vs_en", 32'(marker_en), 32'd0);
    chk("midrst_vs_x", x_out, 32'd0);

    // three accepts in one frame: the last wins, two overwrites
    a_valid = 1'b1; a_x = 11'd1; a_y = 10'd1;
    tick();
    a_x = 11'd2; a_y = 10'd2;
    tick();
    a_x = 11'd3; a_y = 10'd3;
    tick();
    a_valid = 1'b0;
`ifdef OVERLAY_POS_STATS_EN
    chk("drop_cnt", 32'(drop_cnt), 32'd2);
`else
    chk("drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    push_frame(11'd3, 10'd3, 1'b0);
    vsync_pulse(2);
    check_frame("last_wins");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
